// File: rtl/ct_split_buf_pkg.sv
// Shared helpers for the ct_ block family: constant sizing functions used
// when deriving pointer and counter widths from parameters.
package ct_split_buf_pkg;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0, clog2(4) = 2.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ct_fifo_sc.sv
// Single-clock FIFO. DEPTH must be a power of two so the pointers wrap
// naturally; a separate occupancy count disambiguates full from empty.
module ct_fifo_sc
  import ct_split_buf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  assign o_dout = r_mem[r_rd_ptr];

  // Storage write; contents are meaningless while empty.
  // NOTE: the storage array is deliberately left out of reset; only pointers and
  // count define validity, and un-reset RAM maps onto plain memory cells.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ct_split_buf.sv
// Buffered eager-forking split: each input word's flow_id selects a set of
// outputs from a static table, and the word is written into a private FIFO
// per targeted output in one cycle. Input ready never looks at output ready,
// so downstream stalls cannot ripple combinationally to the input.
module ct_split_buf
  import ct_split_buf_pkg::*;
#(
  parameter int               NO             = 2,
  parameter int               WO             = 32,
  parameter int               NF             = 1,
  parameter int               WF             = 1,
  parameter logic [NF*WF-1:0] FLOWS          = '0,
  parameter logic [NF*NO-1:0] ENABLES        = '0,
  parameter int               FLOW_LOC       = 0,
  parameter int               DEPTH          = 4,
  parameter int               DROP_UNMATCHED = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WO-1:0]    i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [NO*WO-1:0] o_data,
  output logic [NO-1:0]    o_valid,
  input  logic [NO-1:0]    i_ready,
  output logic             o_unmatched
);

  logic [WF-1:0] w_flow_id;
  logic [NO-1:0] w_mask;
  logic          w_any_match;
  logic          w_accept;
  logic [NO-1:0] w_push;
  logic [NO-1:0] w_pop;
  logic [NO-1:0] w_full;
  logic [NO-1:0] w_empty;
  logic          r_unmatched;

  assign w_flow_id = i_data[FLOW_LOC +: WF];

  // Flow table lookup; duplicate entries OR their target masks together.
  // NOTE: combinational blocks use blocking assignments with defaults first,
  // which lets the loop accumulate and guarantees no latch is inferred.
  always_comb begin
    w_mask      = '0;
    w_any_match = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (FLOWS[WF*i +: WF] == w_flow_id) begin
        w_mask      = w_mask | ENABLES[NO*i +: NO];
        w_any_match = 1'b1;
      end
    end
  end

  // Input ready: every targeted FIFO must have room; unmatched words either
  // drain into the bit bucket or stall the input.
  always_comb begin
    o_ready = 1'b0;
    if (w_any_match) begin
      o_ready = &(~w_mask | ~w_full);
    end else begin
      o_ready = (DROP_UNMATCHED != 0);
    end
  end

  assign w_accept = i_valid & o_ready;
  assign w_push   = {NO{w_accept}} & w_mask;
  assign w_pop    = ~w_empty & i_ready;
  assign o_valid  = ~w_empty;

  // One-cycle pulse flagging that an unmatched word was discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_unmatched <= 1'b0;
    end else begin
      r_unmatched <= w_accept & ~w_any_match;
    end
  end

  assign o_unmatched = r_unmatched;

  for (genvar j = 0; j < NO; j++) begin : g_out
    ct_fifo_sc #(
      .WIDTH (WO),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push[j]),
      .i_pop   (w_pop[j]),
      .i_din   (i_data),
      .o_dout  (o_data[j*WO +: WO]),
      .o_full  (w_full[j]),
      .o_empty (w_empty[j])
    );
  end

endmodule
